// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
// Bundles every handshake and bus signal of alu_arbiter so the block exposes
// a single bus port next to its scalar clk/rst.
//
//   Request channels  : req{0,1}_valid/ready, req{0,1}_A/B, req{0,1}_ALUop
//   Response channels : resp{0,1}_valid/ready, shared resp_Result,
//                       resp_Overflow/CarryOut/Zero, resp_err
//   ALU side          : alu_A/B/ALUop to the ALU, alu_Result and flags back
//
// Modports
//   slave  : the arbiter itself
//   master : the environment (both requesters plus the external ALU)
// ---------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    // Request channels
    logic                  req0_valid;
    logic                  req1_valid;
    logic                  req0_ready;
    logic                  req1_ready;
    logic [DATA_WIDTH-1:0] req0_A;
    logic [DATA_WIDTH-1:0] req0_B;
    logic [DATA_WIDTH-1:0] req1_A;
    logic [DATA_WIDTH-1:0] req1_B;
    logic [2:0]            req0_ALUop;
    logic [2:0]            req1_ALUop;

    // Response channels
    logic                  resp0_valid;
    logic                  resp1_valid;
    logic                  resp0_ready;
    logic                  resp1_ready;
    logic [DATA_WIDTH-1:0] resp_Result;
    logic                  resp_Overflow;
    logic                  resp_CarryOut;
    logic                  resp_Zero;
    logic                  resp_err;

    // External ALU
    logic [DATA_WIDTH-1:0] alu_A;
    logic [DATA_WIDTH-1:0] alu_B;
    logic [2:0]            alu_ALUop;
    logic [DATA_WIDTH-1:0] alu_Result;
    logic                  alu_Overflow;
    logic                  alu_CarryOut;
    logic                  alu_Zero;

    modport slave (
        input  req0_valid, req1_valid, req0_A, req0_B, req1_A, req1_B,
               req0_ALUop, req1_ALUop, resp0_ready, resp1_ready,
               alu_Result, alu_Overflow, alu_CarryOut, alu_Zero,
        output req0_ready, req1_ready, resp0_valid, resp1_valid,
               resp_Result, resp_Overflow, resp_CarryOut, resp_Zero, resp_err,
               alu_A, alu_B, alu_ALUop
    );

    modport master (
        output req0_valid, req1_valid, req0_A, req0_B, req1_A, req1_B,
               req0_ALUop, req1_ALUop, resp0_ready, resp1_ready,
               alu_Result, alu_Overflow, alu_CarryOut, alu_Zero,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid,
               resp_Result, resp_Overflow, resp_CarryOut, resp_Zero, resp_err,
               alu_A, alu_B, alu_ALUop
    );
endinterface

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one external combinational ALU between two requesters. One operation
// is in flight at a time: IDLE (accept) -> EXEC (ALU settles, result sampled)
// -> RESP (result held for the owning requester until it is taken).
// Ties in IDLE are broken round-robin against the last granted requester.
//
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, aborts any operation in flight
//   bus  : alu_arbiter_if.slave (request, response and ALU signals)
//
// Optional feature (macro ALU_ARB_OP_CHECK_EN)
//   defined     : illegal opcodes (outside {000,001,010,110,111}) are accepted
//                 but never forwarded; the response is all-zero with resp_err=1.
//   not defined : every opcode is forwarded and resp_err is tied to 0.
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q;
    logic                  owner_q;
    logic                  last_q;
    logic [DATA_WIDTH-1:0] alu_a_q;
    logic [DATA_WIDTH-1:0] alu_b_q;
    logic [2:0]            alu_op_q;
    logic [DATA_WIDTH-1:0] res_q;
    logic                  ovf_q;
    logic                  cout_q;
    logic                  zero_q;

    logic                  grant0;
    logic                  grant1;
    logic                  accept;
    logic                  resp_take;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic [2:0]            sel_op;

    // A lone requester always wins; on a tie the one not granted last wins.
    assign grant0 = bus.req0_valid & (~bus.req1_valid | last_q);
    assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
    assign accept = (state_q == IDLE) & (grant0 | grant1);

    assign bus.req0_ready = (state_q == IDLE) & grant0;
    assign bus.req1_ready = (state_q == IDLE) & grant1;

    assign sel_a  = grant1 ? bus.req1_A     : bus.req0_A;
    assign sel_b  = grant1 ? bus.req1_B     : bus.req0_B;
    assign sel_op = grant1 ? bus.req1_ALUop : bus.req0_ALUop;

    // Only the owner's ready can close the response handshake.
    assign resp_take = owner_q ? bus.resp1_ready : bus.resp0_ready;

`ifdef ALU_ARB_OP_CHECK_EN
    logic bad_q;   // accepted opcode was illegal, carried into EXEC
    logic err_q;
    logic sel_legal;

    always_comb begin
        sel_legal = 1'b0;
        case (sel_op)
            3'b000, 3'b001, 3'b010, 3'b110, 3'b111: sel_legal = 1'b1;
            default:                                sel_legal = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;   // req0 wins the first tie
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
`ifdef ALU_ARB_OP_CHECK_EN
            bad_q    <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        owner_q <= grant1;
                        last_q  <= grant1;
                        state_q <= EXEC;
`ifdef ALU_ARB_OP_CHECK_EN
                        bad_q <= ~sel_legal;
                        // Illegal ops leave the ALU inputs untouched.
                        if (sel_legal) begin
                            alu_a_q  <= sel_a;
                            alu_b_q  <= sel_b;
                            alu_op_q <= sel_op;
                        end
`else
                        alu_a_q  <= sel_a;
                        alu_b_q  <= sel_b;
                        alu_op_q <= sel_op;
`endif
                    end
                end
                EXEC: begin
`ifdef ALU_ARB_OP_CHECK_EN
                    if (bad_q) begin
                        res_q  <= '0;
                        ovf_q  <= 1'b0;
                        cout_q <= 1'b0;
                        zero_q <= 1'b0;
                        err_q  <= 1'b1;
                    end else begin
                        res_q  <= bus.alu_Result;
                        ovf_q  <= bus.alu_Overflow;
                        cout_q <= bus.alu_CarryOut;
                        zero_q <= bus.alu_Zero;
                        err_q  <= 1'b0;
                    end
`else
                    res_q  <= bus.alu_Result;
                    ovf_q  <= bus.alu_Overflow;
                    cout_q <= bus.alu_CarryOut;
                    zero_q <= bus.alu_Zero;
`endif
                    state_q <= RESP;
                end
                RESP: begin
                    if (resp_take) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.resp0_valid   = (state_q == RESP) & ~owner_q;
    assign bus.resp1_valid   = (state_q == RESP) &  owner_q;
    assign bus.resp_Result   = res_q;
    assign bus.resp_Overflow = ovf_q;
    assign bus.resp_CarryOut = cout_q;
    assign bus.resp_Zero     = zero_q;
`ifdef ALU_ARB_OP_CHECK_EN
    assign bus.resp_err      = err_q;
`else
    assign bus.resp_err      = 1'b0;
`endif

    assign bus.alu_A     = alu_a_q;
    assign bus.alu_B     = alu_b_q;
    assign bus.alu_ALUop = alu_op_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Directed bench for alu_arbiter with a stand-in ALU attached to the bus.
// Opcodes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; anything else yields
// 32'hDEADBEEF so a forwarded illegal opcode is visible in the response.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc_cnt  = 0;

    typedef struct {
        int who;
        int cyc;
    } acc_t;
    acc_t acc_q[$];

    alu_arbiter_if #(.DATA_WIDTH(32)) bus ();

    alu_arbiter #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Accept log, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.req0_valid && bus.req0_ready) acc_q.push_back('{0, cyc_cnt});
            if (bus.req1_valid && bus.req1_ready) acc_q.push_back('{1, cyc_cnt});
        end
    end

    // Stand-in ALU
    logic [32:0] add_w;
    logic [32:0] sub_w;
    always_comb begin
        add_w = {1'b0, bus.alu_A} + {1'b0, bus.alu_B};
        sub_w = {1'b0, bus.alu_A} + {1'b0, ~bus.alu_B} + 33'd1;
        bus.alu_Overflow = 1'b0;
        bus.alu_CarryOut = 1'b0;
        case (bus.alu_ALUop)
            3'b000: bus.alu_Result = bus.alu_A & bus.alu_B;
            3'b001: bus.alu_Result = bus.alu_A | bus.alu_B;
            3'b010: begin
                bus.alu_Result   = add_w[31:0];
                bus.alu_CarryOut = add_w[32];
                bus.alu_Overflow = (bus.alu_A[31] == bus.alu_B[31]) && (add_w[31] != bus.alu_A[31]);
            end
            3'b110: begin
                bus.alu_Result   = sub_w[31:0];
                bus.alu_CarryOut = sub_w[32];
                bus.alu_Overflow = (bus.alu_A[31] != bus.alu_B[31]) && (sub_w[31] != bus.alu_A[31]);
            end
            3'b111: bus.alu_Result = ($signed(bus.alu_A) < $signed(bus.alu_B)) ? 32'd1 : 32'd0;
            default: bus.alu_Result = 32'hDEADBEEF;
        endcase
        bus.alu_Zero = (bus.alu_Result == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] MAC_ON =
`ifdef ALU_ARB_OP_CHECK_EN
        32'd1;
`else
        32'd0;
`endif

    initial begin
        int   exp_who[6];
        logic saw;

        exp_who = '{0, 1, 0, 1, 0, 1};
        rst = 1'b1;
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.req0_A = 0; bus.req0_B = 0; bus.req0_ALUop = 0;
        bus.req1_A = 0; bus.req1_B = 0; bus.req1_ALUop = 0;
        bus.resp0_ready = 0; bus.resp1_ready = 0;

        // ---- reset then idle ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy",    {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
        chk("rst_rvalid", {30'd0, bus.resp0_valid, bus.resp1_valid}, 32'd0);
        chk("rst_aluA",   bus.alu_A, 32'd0);
        chk("rst_aluop",  {29'd0, bus.alu_ALUop}, 32'd0);
        chk("rst_result", bus.resp_Result, 32'd0);
        chk("rst_err",    {31'd0, bus.resp_err}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("idle_rdy", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
        end

        // ---- single add on req0 ----
        bus.resp0_ready = 1;
        bus.req0_A = 5; bus.req0_B = 3; bus.req0_ALUop = 3'b010; bus.req0_valid = 1;
        #1;
        chk("add_rdy0", {31'd0, bus.req0_ready}, 32'd1);
        step();                         // T+1
        bus.req0_valid = 0;
        chk("add_aluA",  bus.alu_A, 32'd5);
        chk("add_aluop", {29'd0, bus.alu_ALUop}, 32'd2);
        chk("add_rv0_t1", {31'd0, bus.resp0_valid}, 32'd0);
        step();                         // T+2
        chk("add_rv0",  {31'd0, bus.resp0_valid}, 32'd1);
        chk("add_rv1",  {31'd0, bus.resp1_valid}, 32'd0);
        chk("add_res",  bus.resp_Result, 32'd8);
        chk("add_zero", {31'd0, bus.resp_Zero}, 32'd0);
        step();
        chk("add_done", {31'd0, bus.resp0_valid}, 32'd0);

        // ---- contention with backpressure, both valid from reset ----
        rst = 1'b1;
        bus.resp0_ready = 0; bus.resp1_ready = 1;   // non-owner ready is ignored
        bus.req0_A = 32'hF0F0; bus.req0_B = 32'h0FF0; bus.req0_ALUop = 3'b000; bus.req0_valid = 1;
        bus.req1_A = 7;        bus.req1_B = 7;        bus.req1_ALUop = 3'b110; bus.req1_valid = 1;
        #2;
        rst = 1'b0;
        #1;
        chk("cont_rdy", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd2);
        step();
        bus.req0_valid = 0;
        chk("cont_exec_rdy1", {31'd0, bus.req1_ready}, 32'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("hold_rv0", {31'd0, bus.resp0_valid}, 32'd1);
            chk("hold_res", bus.resp_Result, 32'h0000_00F0);
            chk("hold_rdy1", {31'd0, bus.req1_ready}, 32'd0);
            chk("hold_rv1", {31'd0, bus.resp1_valid}, 32'd0);
            step();
        end
        chk("hold_end_rv0", {31'd0, bus.resp0_valid}, 32'd1);
        bus.resp0_ready = 1;
        step();
        bus.resp0_ready = 0;
        chk("cont_rdy1", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd1);
        step();
        bus.req1_valid = 0;
        step();
        chk("sub_rv1",  {30'd0, bus.resp0_valid, bus.resp1_valid}, 32'd1);
        chk("sub_res",  bus.resp_Result, 32'd0);
        chk("sub_zero", {31'd0, bus.resp_Zero}, 32'd1);
        step();

        // ---- fairness under continuous contention ----
        bus.resp0_ready = 1; bus.resp1_ready = 1;
        bus.req0_A = 1; bus.req0_B = 1; bus.req0_ALUop = 3'b010;
        bus.req1_A = 2; bus.req1_B = 4; bus.req1_ALUop = 3'b001;
        acc_q.delete();
        bus.req0_valid = 1; bus.req1_valid = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (acc_q.size() >= 6) break;
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        chk("fair_cnt", acc_q.size(), 32'd6);
        for (int i = 0; i < 6 && i < acc_q.size(); i++) begin
            chk("fair_who", acc_q[i].who, exp_who[i]);
            if (i > 0) chk("fair_gap", acc_q[i].cyc - acc_q[i-1].cyc, 32'd3);
        end
        repeat (3) step();

        // ---- mid-operation reset ----
        bus.req1_A = 1; bus.req1_B = 2; bus.req1_ALUop = 3'b010; bus.req1_valid = 1;
        step();                          // now in EXEC
        bus.req1_valid = 0;
        rst = 1'b1;
        #1;
        chk("mrst_aluA", bus.alu_A, 32'd0);
        step();
        rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            saw = saw | bus.resp0_valid | bus.resp1_valid;
        end
        chk("mrst_noresp", {31'd0, saw}, 32'd0);
        bus.req1_A = 2; bus.req1_B = 2; bus.req1_ALUop = 3'b010; bus.req1_valid = 1;
        #1;
        chk("mrst_rdy1", {31'd0, bus.req1_ready}, 32'd1);
        step();
        bus.req1_valid = 0;
        step();
        chk("mrst_rv1", {31'd0, bus.resp1_valid}, 32'd1);
        chk("mrst_res", bus.resp_Result, 32'd4);
        step();

        // ---- illegal opcode 011 on req1 ----
        bus.req1_A = 1; bus.req1_B = 1; bus.req1_ALUop = 3'b011; bus.req1_valid = 1;
        step();
        bus.req1_valid = 0;
        chk("ill_aluop", {29'd0, bus.alu_ALUop}, MAC_ON != 0 ? 32'd2 : 32'd3);
        chk("ill_aluA",  bus.alu_A, MAC_ON != 0 ? 32'd2 : 32'd1);
        step();
        chk("ill_rv1", {31'd0, bus.resp1_valid}, 32'd1);
        chk("ill_res", bus.resp_Result, MAC_ON != 0 ? 32'd0 : 32'hDEADBEEF);
        chk("ill_err", {31'd0, bus.resp_err}, MAC_ON);
        chk("ill_flags", {29'd0, bus.resp_Overflow, bus.resp_CarryOut, bus.resp_Zero}, 32'd0);
        step();
        chk("ill_done", {31'd0, bus.resp1_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
